// File: rtl/reg_file_pkg.sv
// Shared widths and arbiter state encoding for the register-file arbiter slice.
package reg_file_pkg;
  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 8;
  localparam int NUM_REGS   = 8;
  localparam int BURST_W    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic with last-winner pointer.
// Optional lock/burst hold enabled by REG_FILE_ARB_LOCK_EN.
//
// state | meaning
// IDLE  | no grant last cycle (pointer still remembers last winner)
// OWN0  | requester 0 was granted last cycle
// OWN1  | requester 1 was granted last cycle
module rr_arb2
  import reg_file_pkg::*;
#(
  parameter int MAX_BURST  = 4,
  parameter int RESET_PRIO = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic lock0,
  input  logic lock1,
  output logic gnt0,
  output logic gnt1
);

  arb_state_t r_state;
  logic       r_ptr;
  logic       w_any;
  logic       w_pick1;

  // Both requesting: the one that did not win last time goes next.
  logic w_rr_pick1;
  assign w_rr_pick1 = req1 & (~req0 | ~r_ptr);

`ifdef REG_FILE_ARB_LOCK_EN
  localparam logic [BURST_W-1:0] MAX_CNT = BURST_W'(MAX_BURST);

  logic [BURST_W-1:0] r_burst;
  logic               w_hold0;
  logic               w_hold1;
  logic               w_same_owner;
  logic               w_win_lock;

  assign w_hold0 = (r_state == OWN0) && req0 && lock0 && (r_burst < MAX_CNT);
  assign w_hold1 = (r_state == OWN1) && req1 && lock1 && (r_burst < MAX_CNT);

  always_comb begin
    w_pick1 = w_rr_pick1;
    if (w_hold0)      w_pick1 = 1'b0;
    else if (w_hold1) w_pick1 = 1'b1;
  end

  assign w_same_owner = (gnt0 && (r_state == OWN0)) || (gnt1 && (r_state == OWN1));
  assign w_win_lock   = gnt1 ? lock1 : lock0;

  // Burst counter saturates at MAX_CNT so an uncontended owner keeps it there.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_burst <= '0;
    end else if (gnt0 || gnt1) begin
      if (!w_win_lock)       r_burst <= '0;
      else if (!w_same_owner) r_burst <= BURST_W'(1);
      else if (r_burst != MAX_CNT) r_burst <= r_burst + BURST_W'(1);
    end else begin
      r_burst <= '0;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = lock0 ^ lock1 ^ (MAX_BURST > 0);
  assign w_pick1 = w_rr_pick1;
`endif

  assign w_any = (req0 | req1) & ~rst;
  assign gnt1  = w_any & w_pick1;
  assign gnt0  = w_any & ~w_pick1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= (RESET_PRIO == 0);
      r_state <= IDLE;
    end else if (gnt0 || gnt1) begin
      r_ptr   <= gnt1;
      r_state <= gnt1 ? OWN1 : OWN0;
    end else begin
      r_state <= IDLE;
    end
  end

endmodule

// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter/sequencer for the 8x8 register file's rd0 and write ports.
// Lock/burst hold compiled in with REG_FILE_ARB_LOCK_EN.
module reg_file_arbiter
  import reg_file_pkg::*;
#(
  parameter int MAX_BURST  = 4,
  parameter int RESET_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [REG_ADDR_W-1:0] addr0,
  input  logic [REG_DATA_W-1:0] wdata0,
  input  logic                  lock0,
  output logic                  gnt0,
  output logic                  rvalid0,
  output logic [REG_DATA_W-1:0] rdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [REG_ADDR_W-1:0] addr1,
  input  logic [REG_DATA_W-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [REG_DATA_W-1:0] rdata1,
  output logic [REG_ADDR_W-1:0] rf_rd0_addr,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic                  rf_wr_en,
  output logic [REG_DATA_W-1:0] rf_wr_data,
  input  logic [REG_DATA_W-1:0] rf_out0
);

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_we;
  logic [REG_ADDR_W-1:0] w_addr;
  logic [REG_DATA_W-1:0] w_wdata;
  logic                  w_wr_go;
  logic                  w_rd_go;

  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [REG_ADDR_W-1:0] r_wr_addr;
  logic [REG_DATA_W-1:0] r_wr_data;
  logic                  r_pend0;
  logic                  r_pend1;

  rr_arb2 #(
    .MAX_BURST (MAX_BURST),
    .RESET_PRIO(RESET_PRIO)
  ) u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .lock0(lock0),
    .lock1(lock1),
    .gnt0 (w_gnt0),
    .gnt1 (w_gnt1)
  );

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  assign w_we    = w_gnt1 ? we1    : we0;
  assign w_addr  = w_gnt1 ? addr1  : addr0;
  assign w_wdata = w_gnt1 ? wdata1 : wdata0;
  assign w_wr_go = (w_gnt0 | w_gnt1) & w_we;
  assign w_rd_go = (w_gnt0 | w_gnt1) & ~w_we;

  // File-side lines follow the winner in the grant cycle, otherwise hold.
  assign rf_wr_en    = w_wr_go;
  assign rf_rd0_addr = rst ? '0 : (w_rd_go ? w_addr  : r_rd_addr);
  assign rf_wr_addr  = rst ? '0 : (w_wr_go ? w_addr  : r_wr_addr);
  assign rf_wr_data  = rst ? '0 : (w_wr_go ? w_wdata : r_wr_data);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_pend0   <= 1'b0;
      r_pend1   <= 1'b0;
    end else begin
      if (w_rd_go) r_rd_addr <= w_addr;
      if (w_wr_go) begin
        r_wr_addr <= w_addr;
        r_wr_data <= w_wdata;
      end
      r_pend0 <= w_gnt0 & ~we0;
      r_pend1 <= w_gnt1 & ~we1;
    end
  end

  assign rvalid0 = r_pend0;
  assign rvalid1 = r_pend1;
  assign rdata0  = r_pend0 ? rf_out0 : '0;
  assign rdata1  = r_pend1 ? rf_out0 : '0;

endmodule

// File: doc/reg_file_arbiter.md
Name: reg_file_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the 8x8 register file.
- Owns the register file's rd0 read port and its single write port.
- Grants one access per cycle, read or write, to one requester.
- Drives the file's address, write-enable and write-data lines from the winner, and returns read data one cycle after the grant.
- Sits between the core's two datapath clients (e.g. ALU writeback and operand fetch) and the register file.

Parameters:
- MAX_BURST, 4: max consecutive grants to a locked owner (only used with the optional feature); range 1..15.
- RESET_PRIO, 0: requester that has priority on the first contended cycle after reset (0 or 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0  in  1  requester 0 access request
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  3  requester 0 register index
- wdata0  in  8  requester 0 write data
- lock0  in  1  requester 0 hold-grant request (ignored without the macro)
- gnt0  out  1  requester 0 granted this cycle (combinational)
- rvalid0  out  1  requester 0 read data valid
- rdata0  out  8  requester 0 read data
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1, rdata1: same as above, for requester 1
- rf_rd0_addr  out  3  to register file rd0_addr
- rf_wr_addr  out  3  to register file wr_addr
- rf_wr_en  out  1  to register file wr_en
- rf_wr_data  out  8  to register file wr_data
- rf_out0  in  8  from register file out0 (registered, 1-cycle latency)

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high, sampled on the posedge of clk.
- Reset values:
  - gnt0/1 = 0 and rf_wr_en = 0 while rst is high (combinational gating).
  - rvalid0/1 = 0, rdata0/1 = 0.
  - rf_rd0_addr, rf_wr_addr and rf_wr_data = 0.
  - FSM state = IDLE, last-winner pointer = ~RESET_PRIO, burst counter = 0.
- FSM states: IDLE (no previous winner), OWN0, OWN1. The state records the last granted requester.
  - Any grant moves the FSM to OWN<winner>.
  - A cycle with no request returns it to IDLE but keeps the pointer.
- Arbitration (combinational, same cycle as req):
  - Only one requesting: it is granted.
  - Both requesting: the requester other than the pointer is granted (strict alternation).
  - At most one gnt is high per cycle.
- Granted write:
  - rf_wr_en = 1, rf_wr_addr = addrN, rf_wr_data = wdataN in the grant cycle.
  - The register file updates at the end of that cycle.
- Granted read:
  - rf_rd0_addr = addrN in the grant cycle; rf_wr_en = 0.
  - A registered flag sets rvalidN = 1 in cycle N+1 for exactly one cycle, with rdataN = rf_out0.
  - rdataN = 0 whenever rvalidN = 0.
- Ungranted cycles:
  - rf_rd0_addr holds its last value; rf_wr_en = 0.
- Back-to-back reads: fully pipelined, one response per cycle, in grant order.
- Write then read of the same address in consecutive cycles: the read returns the new data.
- A requester keeps req and all request fields stable until it sees gnt. A read or write is complete when gnt is seen.
- Reset mid-operation: a read granted in the cycle rst rises produces no rvalid. Pending response flags clear.

Optional Feature:
- Macro: REG_FILE_ARB_LOCK_EN
- With the macro defined:
  - If the current owner asserts lockN and reqN, it keeps the grant even when the other requester is waiting, for up to MAX_BURST consecutive grants.
  - The burst counter increments on each locked grant.
  - At MAX_BURST, the next contended cycle goes to the other requester and the counter clears.
  - The counter also clears when lock drops or the owner changes.
- Without the macro:
  - lock0/1 are unused, with no logic connected.
  - Pure alternation as described in Behaviour.

Decomposition:
- Shared package reg_file_pkg:
  - REG_ADDR_W = 3, REG_DATA_W = 8, NUM_REGS = 8.
  - Enum arb_state_t {IDLE, OWN0, OWN1}.
- One natural sub-module: rr_arb2. It holds the 2-way round-robin grant logic, pointer and burst counter.
- The top level does datapath muxing and response tracking.

Test Plan:
- Reset, then req0 write addr 3 data 0xA5; next cycle req0 read addr 3 -> gnt0 both cycles, rvalid0 in the following cycle with rdata0 = 0xA5.
- req0 and req1 reads held high for 4 cycles, RESET_PRIO = 0 -> grants in order r0, r1, r0, r1; rvalid alternates one cycle later with the correct data.
- req1 writes addr 7 = 0x3C while req0 reads addr 7 in the same cycle (pointer favours r1) -> r1 granted first; r0 granted next and returns 0x3C.
- rst asserted in the cycle a read of addr 2 is granted -> no rvalid the next cycle, all outputs 0, FSM IDLE.
- With REG_FILE_ARB_LOCK_EN, MAX_BURST = 4, lock0 = 1 and both requesting -> 4 grants to r0, then 1 to r1, then r0 resumes.
- Without the macro, the same stimulus -> strict alternation; lock0 has no effect.
